// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR width default and maximal-length tap masks
package lfsr_pkg;
  localparam int LFSR_DEFAULT_WIDTH = 4;
  // bit n-1 set for polynomial term x^n; 0 for unsupported widths
  function automatic logic [31:0] lfsr_default_taps(input int width);
    case (width)
      2:  return 32'h0000_0003;
      3:  return 32'h0000_0006;
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      32: return 32'h8020_0003;
      default: return 32'h0;
    endcase
  endfunction
endpackage

// File: rtl/lfsr_feedback.sv
// lfsr_feedback: tap-mask XOR reduction with seed injection
module lfsr_feedback
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_default_taps(WIDTH))
) (
  input  logic [WIDTH-1:0] i_state,
  input  logic             i_seed,
  output logic             o_fb
);
  assign o_fb = ^(i_state & TAPS) ^ i_seed;
endmodule

// File: rtl/lfsr_4bit.sv
// lfsr_4bit: free-running Fibonacci LFSR with seed-injected feedback
// Define LFSR_LOCKUP_RECOVER_EN to break out of the lock-up state for the current seed.
module lfsr_4bit
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_default_taps(WIDTH))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;
  logic             w_fb;
  lfsr_feedback #(.WIDTH(WIDTH), .TAPS(TAPS)) u_feedback (
    .i_state(r_state),
    .i_seed (seed),
    .o_fb   (w_fb)
  );
`ifdef LFSR_LOCKUP_RECOVER_EN
  logic w_lockup;
  // all-ones locks the XNOR form (seed=1), all-zeros the XOR form (seed=0)
  assign w_lockup = seed ? &r_state : ~|r_state;
  assign w_next   = w_lockup ? {{(WIDTH-1){1'b0}}, ~seed} : {r_state[WIDTH-2:0], w_fb};
`else
  assign w_next = {r_state[WIDTH-2:0], w_fb};
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= '0;
    else        r_state <= w_next;
  assign out = r_state;
endmodule

// File: tb/tb_lfsr_4bit.sv
// tb_lfsr_4bit: directed self-checking bench for lfsr_4bit (4-bit and 8-bit instances)
module tb_lfsr_4bit;
  import lfsr_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       seed = 1'b1;
  logic       seed8 = 1'b1;
  logic [3:0] out;
  logic [7:0] out8;
  int n_tests = 0;
  int n_fail = 0;
  logic [3:0] seq [15] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110,
                           4'b1101, 4'b1011, 4'b0110, 4'b1100, 4'b1001,
                           4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000};
  lfsr_4bit dut (.clk(clk), .reset(reset), .seed(seed), .out(out));
  lfsr_4bit #(.WIDTH(8), .TAPS(8'(lfsr_default_taps(8)))) dut8 (
    .clk(clk), .reset(reset), .seed(seed8), .out(out8));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int cnt;
    logic seen0;
    #3;
    check("reset_pre_edge", 32'(out), 32'h0);
    step();
    step();
    check("reset_hold", 32'(out), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check($sformatf("period_%0d", i), 32'(out), 32'(seq[(i + 1) % 15]));
    end
    reset = 1'b0;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("pre_midreset", 32'(out), 32'hD);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_async", 32'(out), 32'h0);
    #2;
    reset = 1'b1;
    step();
    check("after_midreset", 32'(out), 32'h1);
    seed = 1'b0;
    step();
    check("toggle_0", 32'(out), 32'h2);
    step();
    check("toggle_1", 32'(out), 32'h4);
    step();
    check("toggle_2", 32'(out), 32'h9);
    for (int i = 0; i < 8; i++) step();
    check("xor_reach_ones", 32'(out), 32'hF);
    seed = 1'b1;
    step();
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("ones_lockup", 32'(out), 32'h0);
`else
    check("ones_lockup", 32'(out), 32'hF);
`endif
    reset = 1'b0;
    seed = 1'b0;
    #4;
    reset = 1'b1;
`ifdef LFSR_LOCKUP_RECOVER_EN
    step();
    check("zero_lockup_recover", 32'(out), 32'h1);
    step();
    check("zero_lockup_next", 32'(out), 32'h2);
`else
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("zero_lockup_%0d", i), 32'(out), 32'h0);
    end
`endif
    reset = 1'b0;
    seed8 = 1'b1;
    #4;
    reset = 1'b1;
    step();
    check("w8_start", 32'(out8), 32'h01);
    seed8 = 1'b0;
    cnt = 0;
    seen0 = 1'b0;
    do begin
      step();
      cnt++;
      if (out8 == 8'h00) seen0 = 1'b1;
    end while (out8 != 8'h01 && cnt < 300);
    check("w8_period", 32'(cnt), 32'd255);
    check("w8_no_zero", 32'(seen0), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
